euclid_arbiter: RTL and testbench

- Shares one external euclid_dist datapath between NUM_REQ requesters (e.g. CPU slave register file, path-search engine).
- Round-robin arbitration picks one job, drives the datapath operands, and holds them stable for a fixed LATENCY cycles.
- It then captures dp_res and returns it to the owning requester over a valid/ready response handshake.
- Only one job is in flight at a time.

---
 rtl/euclid_arbiter.sv | 142 ++++++++++++++
 tb/tb_euclid_arbiter.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/euclid_arbiter.sv
// Round-robin arbiter that time-shares one external euclid_dist datapath.
// One job in flight: accept -> hold operands LATENCY cycles -> capture -> respond.
module euclid_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 16,
    localparam int IW = $clog2(NUM_REQ),
    localparam int CW = $clog2(LATENCY + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ*128-1:0] req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [NUM_REQ-1:0]     resp_valid,
    input  logic [NUM_REQ-1:0]     resp_ready,
    output logic [31:0]            resp_data,
    output logic [31:0]            dp_x1,
    output logic [31:0]            dp_x2,
    output logic [31:0]            dp_y1,
    output logic [31:0]            dp_y2,
    input  logic [31:0]            dp_res,
    output logic                   busy,
    output logic [IW-1:0]          owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [127:0]    ops_q, ops_d;
    logic [31:0]     resp_data_q, resp_data_d;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;
    logic            accept;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            logic [IW:0] s;
            s = {1'b0, rr_ptr_q} + (IW+1)'(k);
            if (s >= (IW+1)'(NUM_REQ)) begin
                s = s - (IW+1)'(NUM_REQ);
            end
            if (req_valid[s[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = s[IW-1:0];
            end
        end
    end

    assign accept = (state_q == IDLE) && gnt_found;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        resp_valid = '0;
        if (state_q == RESP) begin
            resp_valid[owner_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        ops_d       = ops_q;
        resp_data_d = resp_data_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    ops_d   = req_data[128*int'(gnt_idx) +: 128];
                    owner_d = gnt_idx;
                    cnt_d   = '0;
                    state_d = RUN;
                    if (gnt_idx == IW'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = gnt_idx + 1'b1;
                    end
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(LATENCY - 1)) begin
                    resp_data_d = dp_res;
                    state_d     = RESP;
                end
            end
            RESP: begin
                // Only the owner's ready bit completes the handshake.
                if (resp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            cnt_q       <= '0;
            ops_q       <= '0;
            resp_data_q <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            ops_q       <= ops_d;
            resp_data_q <= resp_data_d;
        end
    end

    assign dp_x1     = ops_q[31:0];
    assign dp_x2     = ops_q[63:32];
    assign dp_y1     = ops_q[95:64];
    assign dp_y2     = ops_q[127:96];
    assign resp_data = resp_data_q;
    assign busy      = (state_q != IDLE);
    assign owner     = owner_q;

endmodule

// File: tb/tb_euclid_arbiter.sv
// Directed bench for euclid_arbiter with a squared-distance datapath model.
module tb_euclid_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [511:0] req_data;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [31:0]  resp_data;
    logic [31:0]  dp_x1, dp_x2, dp_y1, dp_y2;
    logic [31:0]  dp_res;
    logic         busy;
    logic [1:0]   owner;

    logic         use_force;
    logic [31:0]  dp_forced;
    logic [31:0]  dx, dy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] x2tab [4] = '{32'd1, 32'd16, 32'd3, 32'd5};
    logic [31:0] restab [4] = '{32'd1, 32'd100, 32'd25, 32'd169};

    euclid_arbiter #(.NUM_REQ(4), .LATENCY(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .dp_x1     (dp_x1),
        .dp_x2     (dp_x2),
        .dp_y1     (dp_y1),
        .dp_y2     (dp_y2),
        .dp_res    (dp_res),
        .busy      (busy),
        .owner     (owner)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign dx     = dp_x2 - dp_x1;
    assign dy     = dp_y2 - dp_y1;
    assign dp_res = use_force ? dp_forced : (dx * dx + dy * dy);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        use_force  = 1'b0;
        tick();
        #2 rst = 1'b0;
        tick();
    endtask

    task automatic wait_grant(output logic [3:0] g, output bit to);
        to = 1'b1;
        g  = '0;
        #1;
        for (int k = 0; k < 50; k++) begin
            if (req_ready != 4'b0) begin
                to = 1'b0;
                g  = req_ready;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_resp(output int edges, output bit to);
        edges = 0;
        to    = 1'b1;
        for (int k = 0; k < 50; k++) begin
            tick();
            edges++;
            if (resp_valid != 4'b0) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = '0;
        use_force  = 1'b0;
        dp_forced  = '0;
        req_data   = '0;
        req_data[0*128 +: 128] = {32'd0, 32'd0, 32'd1, 32'd0};
        req_data[1*128 +: 128] = {32'd8, 32'd0, 32'd16, 32'd10};
        req_data[2*128 +: 128] = {32'd4, 32'd0, 32'd3, 32'd0};
        req_data[3*128 +: 128] = {32'd12, 32'd0, 32'd5, 32'd0};
        #3;
        checks++;
        if ({req_ready, resp_valid, busy, owner} !== 11'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b exp 0", {req_ready, resp_valid, busy, owner});
        end
        checks++;
        if ({dp_x1, dp_x2, dp_y1, dp_y2, resp_data} !== 160'b0) begin
            errors++;
            $display("FAIL reset_data got %h exp 0", {dp_x1, dp_x2, dp_y1, dp_y2, resp_data});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [3:0] g;
        bit to;
        int e;
        req_valid = 4'b0100;
        wait_grant(g, to);
        checks++;
        if (to || g !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got %b exp 0100", g);
        end
        tick();
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0 || busy !== 1'b1 || owner !== 2'd2) begin
            errors++;
            $display("FAIL single_run got rdy=%b busy=%b own=%0d exp 0000 1 2", req_ready, busy, owner);
        end
        checks++;
        if (dp_x2 !== 32'd3 || dp_y2 !== 32'd4 || dp_x1 !== 32'd0 || dp_y1 !== 32'd0) begin
            errors++;
            $display("FAIL single_ops got x2=%0d y2=%0d exp 3 4", dp_x2, dp_y2);
        end
        wait_resp(e, to);
        checks++;
        if (to || e != 16) begin
            errors++;
            $display("FAIL single_latency got %0d exp 16", e);
        end
        checks++;
        if (resp_valid !== 4'b0100 || resp_data !== 32'd25) begin
            errors++;
            $display("FAIL single_resp got %b %0d exp 0100 25", resp_valid, resp_data);
        end
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 4'b0) begin
            errors++;
            $display("FAIL single_done got busy=%b rv=%b exp 0 0000", busy, resp_valid);
        end
    endtask

    task automatic test_contention();
        logic [3:0] g;
        bit to;
        int e, acc, prev, ex;
        reset_dut();
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        prev = 0;
        for (int j = 0; j < 5; j++) begin
            ex = j % 4;
            wait_grant(g, to);
            checks++;
            if (to || g !== 4'(1 << ex)) begin
                errors++;
                $display("FAIL cont_grant%0d got %b exp %b", j, g, 4'(1 << ex));
            end
            tick();
            acc = cyc;
            if (j > 0) begin
                checks++;
                if (acc - prev != 18) begin
                    errors++;
                    $display("FAIL cont_spacing%0d got %0d exp 18", j, acc - prev);
                end
            end
            prev = acc;
            checks++;
            if (dp_x2 !== x2tab[ex]) begin
                errors++;
                $display("FAIL cont_ops%0d got %0d exp %0d", j, dp_x2, x2tab[ex]);
            end
            wait_resp(e, to);
            checks++;
            if (to || resp_valid !== 4'(1 << ex) || resp_data !== restab[ex]) begin
                errors++;
                $display("FAIL cont_resp%0d got %b %0d exp %b %0d", j, resp_valid, resp_data, 4'(1 << ex), restab[ex]);
            end
            tick();
        end
        req_valid  = '0;
        resp_ready = '0;
    endtask

    task automatic test_wrap();
        logic [3:0] g;
        bit to;
        int e;
        reset_dut();
        resp_ready = 4'b1111;
        req_valid  = 4'b1000;
        wait_grant(g, to);
        checks++;
        if (to || g !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_first got %b exp 1000", g);
        end
        tick();
        req_valid = 4'b1001;
        wait_resp(e, to);
        tick();
        wait_grant(g, to);
        checks++;
        if (to || g !== 4'b0001) begin
            errors++;
            $display("FAIL wrap_second got %b exp 0001", g);
        end
        tick();
        wait_resp(e, to);
        tick();
        wait_grant(g, to);
        checks++;
        if (to || g !== 4'b1000) begin
            errors++;
            $display("FAIL wrap_third got %b exp 1000", g);
        end
        tick();
        req_valid = '0;
        wait_resp(e, to);
        tick();
        resp_ready = '0;
    endtask

    task automatic test_backpressure();
        logic [3:0] g;
        bit to;
        int e, bad;
        reset_dut();
        req_valid = 4'b0010;
        wait_grant(g, to);
        checks++;
        if (to || g !== 4'b0010) begin
            errors++;
            $display("FAIL bp_grant got %b exp 0010", g);
        end
        tick();
        req_valid = 4'b0001;
        wait_resp(e, to);
        checks++;
        if (to || resp_valid !== 4'b0010 || resp_data !== 32'd100) begin
            errors++;
            $display("FAIL bp_resp got %b %0d exp 0010 100", resp_valid, resp_data);
        end
        use_force  = 1'b1;
        dp_forced  = 32'hDEADBEEF;
        resp_ready = 4'b1101;
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (resp_valid !== 4'b0010 || resp_data !== 32'd100 || req_ready !== 4'b0) begin
                bad++;
            end
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold got %0d bad cycles exp 0", bad);
        end
        resp_ready = 4'b0010;
        tick();
        resp_ready = '0;
        checks++;
        if (busy !== 1'b0 || req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL bp_idle got busy=%b rdy=%b exp 0 0001", busy, req_ready);
        end
        use_force = 1'b0;
        tick();
        req_valid = '0;
        checks++;
        if (owner !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_next got own=%0d busy=%b exp 0 1", owner, busy);
        end
        resp_ready = 4'b1111;
        wait_resp(e, to);
        tick();
        resp_ready = '0;
    endtask

    task automatic test_capture();
        logic [3:0] g;
        bit to;
        reset_dut();
        use_force = 1'b1;
        dp_forced = 32'h1;
        req_valid = 4'b0100;
        wait_grant(g, to);
        tick();
        req_valid = '0;
        for (int k = 0; k < 15; k++) begin
            tick();
        end
        dp_forced = 32'h5A5A5A5A;
        tick();
        dp_forced = 32'h1;
        checks++;
        if (to || resp_valid !== 4'b0100 || resp_data !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL capture got %b %h exp 0100 5a5a5a5a", resp_valid, resp_data);
        end
        tick();
        tick();
        checks++;
        if (resp_data !== 32'h5A5A5A5A) begin
            errors++;
            $display("FAIL capture_hold got %h exp 5a5a5a5a", resp_data);
        end
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        use_force  = 1'b0;
    endtask

    task automatic test_midjob_reset();
        logic [3:0] g;
        bit to;
        int e, seen;
        reset_dut();
        req_valid = 4'b0010;
        wait_grant(g, to);
        tick();
        req_valid = '0;
        for (int k = 0; k < 7; k++) begin
            tick();
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, resp_valid, busy, owner} !== 11'b0 ||
            {dp_x1, dp_x2, dp_y1, dp_y2, resp_data} !== 160'b0) begin
            errors++;
            $display("FAIL midrst_outs got busy=%b own=%0d x2=%0d exp all 0", busy, owner, dp_x2);
        end
        #2 rst = 1'b0;
        resp_ready = 4'b1111;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (resp_valid !== 4'b0) begin
                seen++;
            end
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midrst_noresp got %0d exp 0", seen);
        end
        req_valid = 4'b1000;
        wait_grant(g, to);
        checks++;
        if (to || g !== 4'b1000) begin
            errors++;
            $display("FAIL midrst_grant got %b exp 1000", g);
        end
        tick();
        req_valid = '0;
        checks++;
        if (owner !== 2'd3) begin
            errors++;
            $display("FAIL midrst_owner got %0d exp 3", owner);
        end
        wait_resp(e, to);
        checks++;
        if (to || resp_valid !== 4'b1000 || resp_data !== 32'd169) begin
            errors++;
            $display("FAIL midrst_resp got %b %0d exp 1000 169", resp_valid, resp_data);
        end
        tick();
        resp_ready = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_wrap();
        test_backpressure();
        test_capture();
        test_midjob_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
